// File: rtl/countdown_timer_display_pkg.sv
// Shared types, geometry defaults, segment patterns and BCD helpers for the
// countdown timer and its seven-segment raster.
package countdown_timer_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  typedef logic [3:0]  bcd_digit_t;
  typedef logic [11:0] bcd3_t;

  localparam int unsigned TICK_DIV_DEF    = 50_000_000;
  localparam bcd3_t       START_VAL_DEF   = 12'h300;
  localparam logic [9:0]  X0_DEF          = 10'd535;
  localparam logic [9:0]  Y0_DEF          = 10'd50;
  localparam logic [9:0]  DIGIT_W_DEF     = 10'd25;
  localparam logic [9:0]  DIGIT_H_DEF     = 10'd50;
  localparam logic [9:0]  DIGIT_PITCH_DEF = 10'd35;

  // Segment masks, bit order {a,b,c,d,e,f,g}.
  localparam logic [6:0] SEG_MASK [10] = '{
    7'b1111110,  // 0
    7'b0110000,  // 1
    7'b1101101,  // 2
    7'b1111001,  // 3
    7'b0110011,  // 4
    7'b1011011,  // 5
    7'b1011111,  // 6
    7'b1110000,  // 7
    7'b1111111,  // 8
    7'b1111011   // 9
  };

  function automatic bcd_digit_t clamp_digit(bcd_digit_t d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic bcd3_t bcd_clamp(bcd3_t v);
    return {clamp_digit(v[11:8]), clamp_digit(v[7:4]), clamp_digit(v[3:0])};
  endfunction

  // Decrement by one with borrow; 000 stays 000.
  function automatic bcd3_t bcd_dec(bcd3_t v);
    bcd_digit_t h;
    bcd_digit_t t;
    bcd_digit_t u;
    h = v[11:8];
    t = v[7:4];
    u = v[3:0];
    if (v == 12'h000) return v;
    if (u != 4'd0) begin
      u = u - 4'd1;
    end else begin
      u = 4'd9;
      if (t != 4'd0) begin
        t = t - 4'd1;
      end else begin
        t = 4'd9;
        h = h - 4'd1;
      end
    end
    return {h, t, u};
  endfunction

  // Add ten with carry into hundreds; anything past 999 pins at 999.
  function automatic bcd3_t bcd_add10_sat(bcd3_t v);
    bcd_digit_t h;
    bcd_digit_t t;
    h = v[11:8];
    t = v[7:4];
    if (t != 4'd9) begin
      t = t + 4'd1;
    end else begin
      t = 4'd0;
      if (h != 4'd9) h = h + 4'd1;
      else return 12'h999;
    end
    return {h, t, v[3:0]};
  endfunction

endpackage

// File: rtl/countdown_timer_display_if.sv
// Control, status and pixel-query signals of the countdown timer.
interface countdown_timer_display_if;
  logic        i_load;
  logic [11:0] i_load_val;
  logic        i_run;
  logic        i_bonus;
  logic [9:0]  i_x;
  logic [9:0]  i_y;
  logic [11:0] o_bcd;
  logic        o_running;
  logic        o_expired;
  logic        o_time_up;
  logic        o_pix;

  modport master (
    output i_load, i_load_val, i_run, i_bonus, i_x, i_y,
    input  o_bcd, o_running, o_expired, o_time_up, o_pix
  );

  modport slave (
    input  i_load, i_load_val, i_run, i_bonus, i_x, i_y,
    output o_bcd, o_running, o_expired, o_time_up, o_pix
  );
endinterface

// File: rtl/countdown_timer_display_seg_glyph_raster.sv
// Combinational hit test of one pixel against the 1-pixel outline of one
// seven-segment digit whose top-left corner is (org_x, org_y).
module seg_glyph_raster
  import countdown_timer_display_pkg::*;
#(
  parameter logic [9:0] DIGIT_W = DIGIT_W_DEF,
  parameter logic [9:0] DIGIT_H = DIGIT_H_DEF
) (
  input  bcd_digit_t digit,
  input  logic       blank,
  input  logic [9:0] org_x,
  input  logic [9:0] org_y,
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  output logic       hit
);

  localparam logic [9:0] HALF_H = DIGIT_H >> 1;

  logic [9:0] x_right;
  logic [9:0] y_mid;
  logic [9:0] y_bot;
  logic       in_span;
  logic       upper;
  logic       lower;
  logic [6:0] segs;
  logic [6:0] mask;

  assign x_right = org_x + DIGIT_W;
  assign y_mid   = org_y + HALF_H;
  assign y_bot   = org_y + DIGIT_H;

  assign in_span = (i_x >= org_x) && (i_x <= x_right);
  assign upper   = (i_y >= org_y) && (i_y <= y_mid);
  assign lower   = (i_y >= y_mid) && (i_y <= y_bot);

  // Geometric membership per segment, {a,b,c,d,e,f,g}.
  assign segs = {
    in_span && (i_y == org_y),
    (i_x == x_right) && upper,
    (i_x == x_right) && lower,
    in_span && (i_y == y_bot),
    (i_x == org_x) && lower,
    (i_x == org_x) && upper,
    in_span && (i_y == y_mid)
  };

  assign mask = (digit <= 4'd9) ? SEG_MASK[digit] : 7'd0;
  assign hit  = !blank && |(segs & mask);

endmodule

// File: rtl/countdown_timer_display.sv
// BCD countdown game timer (000-999 s) with a registered seven-segment
// pixel flag for the frame compositor.
//
//  state      | meaning
//  -----------+-----------------------------------------------------
//  ST_IDLE    | value loaded, waiting for i_run
//  ST_RUN     | prescaler advancing, one decrement per second
//  ST_PAUSE   | i_run low; prescaler frozen, partial second kept
//  ST_EXPIRED | reached 000; only i_load or i_rst leave
module countdown_timer_display
  import countdown_timer_display_pkg::*;
#(
  parameter int unsigned TICK_DIV    = TICK_DIV_DEF,
  parameter bcd3_t       START_VAL   = START_VAL_DEF,
  parameter logic [9:0]  X0          = X0_DEF,
  parameter logic [9:0]  Y0          = Y0_DEF,
  parameter logic [9:0]  DIGIT_W     = DIGIT_W_DEF,
  parameter logic [9:0]  DIGIT_H     = DIGIT_H_DEF,
  parameter logic [9:0]  DIGIT_PITCH = DIGIT_PITCH_DEF
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  countdown_timer_display_if.slave        bus
);

  localparam int         PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [9:0] XD1   = X0 + DIGIT_PITCH;
  localparam logic [9:0] XD2   = X0 + DIGIT_PITCH + DIGIT_PITCH;

  state_t           state_q, state_d;
  bcd3_t            bcd_q, bcd_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             time_up_q, time_up_d;
  logic             pix_q;

  logic             run_en;
  logic             tick;
  bcd3_t            bcd_ticked;
  bcd3_t            load_clamped;
  logic             blank_h;
  logic             blank_t;
  logic [2:0]       digit_hit;

  assign run_en       = (state_q == ST_RUN) && bus.i_run;
  assign tick         = run_en && (pre_q == PRE_W'(TICK_DIV - 1));
  assign bcd_ticked   = tick ? bcd_dec(bcd_q) : bcd_q;
  assign load_clamped = bcd_clamp(bus.i_load_val);

  // Next state, prescaler and value; load overrides bonus and tick.
  always_comb begin
    state_d   = state_q;
    bcd_d     = bcd_q;
    pre_d     = pre_q;
    time_up_d = 1'b0;
    if (bus.i_load) begin
      bcd_d   = load_clamped;
      pre_d   = '0;
      state_d = (load_clamped == 12'h000) ? ST_EXPIRED : ST_IDLE;
    end else if (state_q != ST_EXPIRED) begin
      if (run_en) pre_d = tick ? '0 : pre_q + 1'b1;
      // Decrement first, then add the bonus, so saturation sees the net +9.
      bcd_d = bus.i_bonus ? bcd_add10_sat(bcd_ticked) : bcd_ticked;
      case (state_q)
        ST_IDLE:  if (bus.i_run) state_d = ST_RUN;
        ST_RUN: begin
          if (tick && (bcd_d == 12'h000)) begin
            state_d   = ST_EXPIRED;
            time_up_d = 1'b1;
          end else if (!bus.i_run) begin
            state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: if (bus.i_run) state_d = ST_RUN;
        default:  state_d = state_q;
      endcase
    end
  end

  // State, value, prescaler and time-up pulse registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      bcd_q     <= START_VAL;
      pre_q     <= '0;
      time_up_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcd_q     <= bcd_d;
      pre_q     <= pre_d;
      time_up_q <= time_up_d;
    end
  end

  assign blank_h = (bcd_q[11:8] == 4'd0);
  assign blank_t = blank_h && (bcd_q[7:4] == 4'd0);

  seg_glyph_raster #(.DIGIT_W(DIGIT_W), .DIGIT_H(DIGIT_H)) u_glyph_h (
    .digit(bcd_q[11:8]), .blank(blank_h), .org_x(X0), .org_y(Y0),
    .i_x(bus.i_x), .i_y(bus.i_y), .hit(digit_hit[0])
  );

  seg_glyph_raster #(.DIGIT_W(DIGIT_W), .DIGIT_H(DIGIT_H)) u_glyph_t (
    .digit(bcd_q[7:4]), .blank(blank_t), .org_x(XD1), .org_y(Y0),
    .i_x(bus.i_x), .i_y(bus.i_y), .hit(digit_hit[1])
  );

  seg_glyph_raster #(.DIGIT_W(DIGIT_W), .DIGIT_H(DIGIT_H)) u_glyph_u (
    .digit(bcd_q[3:0]), .blank(1'b0), .org_x(XD2), .org_y(Y0),
    .i_x(bus.i_x), .i_y(bus.i_y), .hit(digit_hit[2])
  );

  // Pixel flag registered one cycle behind the scan position.
  always_ff @(posedge i_clk) begin
    if (i_rst) pix_q <= 1'b0;
    else       pix_q <= |digit_hit;
  end

  assign bus.o_bcd     = bcd_q;
  assign bus.o_running = (state_q == ST_RUN);
  assign bus.o_expired = (state_q == ST_EXPIRED);
  assign bus.o_time_up = time_up_q;
  assign bus.o_pix     = pix_q;

endmodule

// File: tb/tb_countdown_timer_display.sv
// Self-checking bench for countdown_timer_display with a one-second tick of
// four clocks. Directed scenarios use hand-derived constants; a randomized
// run is compared against an integer-seconds reference model.
module tb_countdown_timer_display;

  localparam int TD = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  // reference model: seconds as a plain integer, mode 0 idle 1 run 2 pause 3 expired
  int   m_val;
  int   m_mode;
  int   m_phase;
  bit   m_tu;
  bit   m_pix;

  countdown_timer_display_if bus();

  countdown_timer_display #(.TICK_DIV(TD)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] to_bcd(int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic string glyph(int d);
    case (d)
      0: return "abcdef";
      1: return "bc";
      2: return "abdeg";
      3: return "abcdg";
      4: return "bcfg";
      5: return "acdfg";
      6: return "acdefg";
      7: return "abc";
      8: return "abcdefg";
      default: return "abcdfg";
    endcase
  endfunction

  function automatic bit model_pix(int val, int x, int y);
    int    d[3];
    int    xd;
    string lit;
    d[0] = val / 100;
    d[1] = (val / 10) % 10;
    d[2] = val % 10;
    for (int k = 0; k < 3; k++) begin
      if (k == 0 && d[0] == 0) continue;
      if (k == 1 && d[0] == 0 && d[1] == 0) continue;
      xd  = 535 + 35 * k;
      lit = glyph(d[k]);
      for (int s = 0; s < lit.len(); s++) begin
        case (lit[s])
          "a": if (y == 50  && x >= xd && x <= xd + 25) return 1'b1;
          "g": if (y == 75  && x >= xd && x <= xd + 25) return 1'b1;
          "d": if (y == 100 && x >= xd && x <= xd + 25) return 1'b1;
          "b": if (x == xd + 25 && y >= 50 && y <= 75)  return 1'b1;
          "c": if (x == xd + 25 && y >= 75 && y <= 100) return 1'b1;
          "f": if (x == xd && y >= 50 && y <= 75)       return 1'b1;
          "e": if (x == xd && y >= 75 && y <= 100)      return 1'b1;
          default: ;
        endcase
      end
    end
    return 1'b0;
  endfunction

  task automatic model_update(input bit ld, input logic [11:0] lv, input bit run, input bit bon);
    int h, t, u, nv;
    bit tk;
    if (ld) begin
      h = (lv[11:8] > 9) ? 9 : int'(lv[11:8]);
      t = (lv[7:4]  > 9) ? 9 : int'(lv[7:4]);
      u = (lv[3:0]  > 9) ? 9 : int'(lv[3:0]);
      m_val   = h * 100 + t * 10 + u;
      m_phase = 0;
      m_mode  = (m_val == 0) ? 3 : 0;
      m_tu    = 1'b0;
    end else if (m_mode == 3) begin
      m_tu = 1'b0;
    end else begin
      tk = (m_mode == 1) && run && (m_phase == TD - 1);
      if (m_mode == 1 && run) m_phase = (m_phase + 1) % TD;
      nv = m_val - (tk ? 1 : 0) + (bon ? 10 : 0);
      if (nv > 999) nv = 999;
      m_tu  = tk && (nv == 0);
      m_val = nv;
      if (m_tu)                   m_mode = 3;
      else if (m_mode == 0 && run)  m_mode = 1;
      else if (m_mode == 1 && !run) m_mode = 2;
      else if (m_mode == 2 && run)  m_mode = 1;
    end
  endtask

  // one clock with the given inputs; outputs are then read 1 ns after the edge
  task automatic step(input bit ld, input logic [11:0] lv, input bit run, input bit bon);
    bus.i_load     = ld;
    bus.i_load_val = lv;
    bus.i_run      = run;
    bus.i_bonus    = bon;
    m_pix = model_pix(m_val, int'(bus.i_x), int'(bus.i_y));
    @(posedge clk);
    #1;
    model_update(ld, lv, run, bon);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_load = 1'b0; bus.i_load_val = '0; bus.i_run = 1'b0; bus.i_bonus = 1'b0;
    bus.i_x = 10'd605; bus.i_y = 10'd50;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.o_bcd !== 12'h300) begin n_err++; $display("FAIL reset_bcd: got %03h want 300", bus.o_bcd); end
    n_cmp++;
    if ({bus.o_running, bus.o_expired, bus.o_time_up, bus.o_pix} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 0000", {bus.o_running, bus.o_expired, bus.o_time_up, bus.o_pix});
    end
    m_val = 300; m_mode = 0; m_phase = 0; m_tu = 1'b0;
    rst = 1'b0;
    bus.i_x = 10'd0; bus.i_y = 10'd0;
  endtask

  task automatic test_expire();
    int pulses;
    logic [11:0] exp;
    step(1'b1, 12'h003, 1'b0, 1'b0);
    n_cmp++;
    if (bus.o_bcd !== 12'h003 || bus.o_running !== 1'b0) begin
      n_err++; $display("FAIL t1_load: got %03h run=%b want 003 run=0", bus.o_bcd, bus.o_running);
    end
    step(1'b0, 12'h000, 1'b1, 1'b0);
    n_cmp++;
    if (bus.o_running !== 1'b1) begin n_err++; $display("FAIL t1_start: running=%b want 1", bus.o_running); end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 12'h000, 1'b1, 1'b0);
      if (bus.o_time_up) pulses++;
      exp = to_bcd(3 - (i + 1) / 4);
      n_cmp++;
      if (bus.o_bcd !== exp) begin n_err++; $display("FAIL t1_count[%0d]: got %03h want %03h", i, bus.o_bcd, exp); end
    end
    n_cmp++;
    if (bus.o_time_up !== 1'b1 || bus.o_expired !== 1'b1) begin
      n_err++; $display("FAIL t1_at_zero: time_up=%b expired=%b want 1 1", bus.o_time_up, bus.o_expired);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 12'h000, 1'b1, 1'b0);
      if (bus.o_time_up) pulses++;
    end
    n_cmp++;
    if (pulses !== 1 || bus.o_expired !== 1'b1 || bus.o_bcd !== 12'h000) begin
      n_err++; $display("FAIL t1_after: pulses=%0d expired=%b bcd=%03h want 1 1 000", pulses, bus.o_expired, bus.o_bcd);
    end
  endtask

  task automatic test_borrow();
    logic [11:0] exp;
    step(1'b1, 12'h100, 1'b0, 1'b0);
    step(1'b0, 12'h000, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 12'h000, 1'b1, 1'b0);
      exp = to_bcd(100 - (i + 1) / 4);
      n_cmp++;
      if (bus.o_bcd !== exp) begin n_err++; $display("FAIL t2_borrow[%0d]: got %03h want %03h", i, bus.o_bcd, exp); end
    end
    step(1'b0, 12'h000, 1'b0, 1'b0);
  endtask

  task automatic test_bonus();
    step(1'b1, 12'h995, 1'b0, 1'b0);
    step(1'b0, 12'h000, 1'b0, 1'b1);
    n_cmp++;
    if (bus.o_bcd !== 12'h999) begin n_err++; $display("FAIL t3_sat: got %03h want 999", bus.o_bcd); end
    step(1'b1, 12'h095, 1'b0, 1'b0);
    step(1'b0, 12'h000, 1'b0, 1'b1);
    n_cmp++;
    if (bus.o_bcd !== 12'h105) begin n_err++; $display("FAIL t3_carry: got %03h want 105", bus.o_bcd); end
    step(1'b1, 12'hFA3, 1'b0, 1'b0);
    n_cmp++;
    if (bus.o_bcd !== 12'h993) begin n_err++; $display("FAIL t3_clamp: got %03h want 993", bus.o_bcd); end
    step(1'b1, 12'h050, 1'b0, 1'b0);
    step(1'b0, 12'h000, 1'b1, 1'b0);
    repeat (3) step(1'b0, 12'h000, 1'b1, 1'b0);
    n_cmp++;
    if (bus.o_bcd !== 12'h050) begin n_err++; $display("FAIL t3_pre_tick: got %03h want 050", bus.o_bcd); end
    step(1'b0, 12'h000, 1'b1, 1'b1);
    n_cmp++;
    if (bus.o_bcd !== 12'h059) begin n_err++; $display("FAIL t3_bonus_tick: got %03h want 059", bus.o_bcd); end
    step(1'b0, 12'h000, 1'b0, 1'b0);
  endtask

  task automatic test_pause();
    step(1'b1, 12'h010, 1'b0, 1'b0);
    step(1'b0, 12'h000, 1'b1, 1'b0);
    repeat (2) step(1'b0, 12'h000, 1'b1, 1'b0);
    repeat (10) step(1'b0, 12'h000, 1'b0, 1'b0);
    n_cmp++;
    if (bus.o_bcd !== 12'h010 || bus.o_running !== 1'b0) begin
      n_err++; $display("FAIL t4_paused: bcd=%03h run=%b want 010 0", bus.o_bcd, bus.o_running);
    end
    step(1'b0, 12'h000, 1'b1, 1'b0);
    step(1'b0, 12'h000, 1'b1, 1'b0);
    n_cmp++;
    if (bus.o_bcd !== 12'h010) begin n_err++; $display("FAIL t4_early: got %03h want 010", bus.o_bcd); end
    step(1'b0, 12'h000, 1'b1, 1'b0);
    n_cmp++;
    if (bus.o_bcd !== 12'h009) begin n_err++; $display("FAIL t4_resume_tick: got %03h want 009", bus.o_bcd); end
  endtask

  task automatic test_load_zero();
    logic [11:0] exp;
    step(1'b1, 12'h000, 1'b0, 1'b0);
    n_cmp++;
    if (bus.o_expired !== 1'b1 || bus.o_time_up !== 1'b0) begin
      n_err++; $display("FAIL t5_load0: expired=%b time_up=%b want 1 0", bus.o_expired, bus.o_time_up);
    end
    repeat (3) step(1'b0, 12'h000, 1'b1, 1'b1);
    n_cmp++;
    if (bus.o_bcd !== 12'h000 || bus.o_expired !== 1'b1 || bus.o_running !== 1'b0) begin
      n_err++; $display("FAIL t5_ignored: bcd=%03h exp=%b run=%b want 000 1 0", bus.o_bcd, bus.o_expired, bus.o_running);
    end
    step(1'b1, 12'h005, 1'b0, 1'b0);
    step(1'b0, 12'h000, 1'b1, 1'b0);
    repeat (2) step(1'b0, 12'h000, 1'b1, 1'b0);
    step(1'b1, 12'h005, 1'b1, 1'b0);
    n_cmp++;
    if (bus.o_bcd !== 12'h005 || bus.o_running !== 1'b0 || bus.o_expired !== 1'b0) begin
      n_err++; $display("FAIL t5_reload: bcd=%03h run=%b exp=%b want 005 0 0", bus.o_bcd, bus.o_running, bus.o_expired);
    end
    step(1'b0, 12'h000, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 12'h000, 1'b1, 1'b0);
      exp = to_bcd(5 - (i + 1) / 4);
      n_cmp++;
      if (bus.o_bcd !== exp) begin n_err++; $display("FAIL t5_fresh_second[%0d]: got %03h want %03h", i, bus.o_bcd, exp); end
    end
    step(1'b0, 12'h000, 1'b0, 1'b0);
  endtask

  task automatic test_raster();
    int xs[5] = '{605, 630, 605, 535, 640};
    int ys[5] = '{50, 60, 100, 50, 75};
    bit want[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    step(1'b1, 12'h007, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus.i_x = 10'(xs[i]);
      bus.i_y = 10'(ys[i]);
      step(1'b0, 12'h000, 1'b0, 1'b0);
      n_cmp++;
      if (bus.o_pix !== want[i]) begin
        n_err++; $display("FAIL t6_pix(%0d,%0d): got %b want %b", xs[i], ys[i], bus.o_pix, want[i]);
      end
    end
  endtask

  task automatic test_random();
    bit          run;
    bit          ld;
    bit          bon;
    logic [11:0] lv;
    logic [15:0] got;
    logic [15:0] exp;
    run = 1'b0;
    for (int i = 0; i < 600; i++) begin
      ld  = ($urandom % 16) == 0;
      lv  = (($urandom % 3) == 0) ? 12'($urandom % 4) : 12'($urandom);
      bon = ($urandom % 10) == 0;
      if (($urandom % 8) == 0) run = !run;
      bus.i_x = 10'(530 + $urandom % 115);
      bus.i_y = 10'(45 + $urandom % 60);
      step(ld, lv, run, bon);
      got = {bus.o_bcd, bus.o_running, bus.o_expired, bus.o_time_up, bus.o_pix};
      exp = {to_bcd(m_val), m_mode == 1, m_mode == 3, m_tu, m_pix};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL rand[%0d] {bcd,run,exp,tu,pix}: got %04h want %04h", i, got, exp);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_expire();
    test_borrow();
    test_bonus();
    test_pause();
    test_load_zero();
    test_raster();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
